sdr_dev_resp: RTL and testbench
===============================

// Module: sdr_dev_resp
// PURPOSE
//  Synthesizable SDRAM device responder: the memory end of the SDR command bus driven by the SDR controller.
//  Decodes CSn/RASn/CASn/WEn commands and tracks the init sequence, per-bank open rows, mode register and bursts.
//  Stores data in a small on-chip array; returns read data after CAS latency. Flags protocol violations.
//  Used as the DUT-side partner in controller benches and in FPGA loopback builds.
// PARAMETERS
//  DATA_W  16  data bus width
//  ROW_W   4   row address bits used (storage depth per bank = 2^(ROW_W+COL_W))
//  COL_W   4   column address bits used (A[COL_W-1:0])
//  T_RCD   2   min cycles ACT->READ/WRITE same bank
//  T_RP    2   min cycles PRE->ACT same bank
// PORTS
//  pclk      in   1       clock
//  preset    in   1       synchronous reset, active-high
//  sdr_CKE   in   1       clock enable; 0 = all inputs ignored, all state frozen
//  sdr_CSn   in   1       chip select, active-low
//  sdr_RASn  in   1       command bit
//  sdr_CASn  in   1       command bit
//  sdr_WEn   in   1       command bit
//  sdr_BA    in   2       bank address
//  sdr_A     in   16      row (ACT) / column + A10 (RD/WR/PRE) / mode (MRS)
//  sdr_D     in   DATA_W  write data
//  sdr_DQM   in   1       1 = mask current write beat (no store) / read beat (sdr_Q_vld stays 0)
//  sdr_Q     out  DATA_W  read data
//  sdr_Q_vld out  1       sdr_Q valid this cycle
//  dev_rdy   out  1       init sequence complete
//  proto_err out  4       sticky: [0] cmd before ready, [1] RD/WR to closed bank, [2] ACT to open bank, [3] timing
// BEHAVIOUR
//  Reset: sdr_Q=0, sdr_Q_vld=0, dev_rdy=0, proto_err=0, all banks closed, CL=2, BL=1, bursts/pipeline flushed.
//  Decode when CKE=1 and CSn=0 {RASn,CASn,WEn}: 111 NOP, 011 ACT, 101 READ, 100 WRITE, 010 PRE (A10=1 all banks),
//   001 REF, 000 MRS. CSn=1 = DESEL (same as NOP).
//  Init FSM: WAIT_PRE -(PRE all)-> REF1 -(REF)-> REF2 -(REF)-> WAIT_MRS -(MRS)-> READY (dev_rdy=1 next cycle).
//   Any other non-NOP command during init: ignored, proto_err[0] set. REF in READY: accepted, no state change.
//  MRS: A[6:4]=CL (2 or 3; other values keep old CL, set proto_err[3]); A[2:0]=BL code 0/1/2/3 -> 1/2/4/8, others -> 1.
//  ACT: opens row A[ROW_W-1:0] in BA; if bank already open, row unchanged, proto_err[2] set.
//  WRITE: beat 0 taken from sdr_D in the command cycle; beats 1..BL-1 on following cycles.
//  READ: beat k appears on sdr_Q with sdr_Q_vld=1 exactly CL cycles after its issue cycle (cmd cycle + k).
//  Column order: sequential, wrapping inside the BL-aligned block (BL=4, start 14 -> 14,15,12,13).
//  RD/WR to closed bank: no access, proto_err[1] set. Address bits above ROW_W/COL_W ignored.
//  New READ/WRITE during a burst truncates it; read beats already issued still emerge after CL.
//  PRE of the bank with an active burst terminates the burst next cycle.
//  Read and write to the same column in the same cycle cannot occur (one command/cycle); write-then-read
//   returns the newly written data.
//  CKE=0: command ignored, burst counter and read pipeline frozen, sdr_Q/sdr_Q_vld hold.
//  Reset mid-burst or mid-init: returns to WAIT_PRE; array contents are not cleared.
// CONFIGURATION
//  SDR_RESP_TCHK_EN defined: per-bank cycle counters; ACT->RD/WR < T_RCD or PRE->ACT < T_RP sets proto_err[3];
//   violating command is still executed.
//  Undefined: no timing counters; proto_err[3] set only by invalid MRS CL.
// TESTING
//  Reset, PRE-all, REF, REF, MRS A=0x0022 -> dev_rdy=1 one cycle after MRS, CL=2 BL=4, proto_err=0.
//  ACT before init done -> proto_err=4'b0001, dev_rdy stays 0.
//  ACT BA=1 row 3, 2 NOPs, WRITE col 14, data 0xA000..0xA003 -> stored at cols 14,15,12,13.
//  READ BA=1 col 12 -> sdr_Q_vld at cmd+2..cmd+5, data 0xA002,0xA003,0xA000,0xA001.
//  READ BA=2 (closed) -> no sdr_Q_vld, proto_err[1]=1; ACT BA=1 again -> proto_err[2]=1.
//  With SDR_RESP_TCHK_EN: READ one cycle after ACT -> proto_err[3]=1; preset mid-burst -> sdr_Q_vld=0 next cycle.

Source files
------------

// File: rtl/sdr_dev_resp_if.sv
// sdr_dev_resp_if: SDR command/data bus between an SDR controller and the
// sdr_dev_resp device model.
//   master : controller side (drives command, address, write data, mask)
//   slave  : device side (drives read data, valid, ready, error flags)
// Signals:
//   sdr_CKE, sdr_CSn, sdr_RASn, sdr_CASn, sdr_WEn  command strobes
//   sdr_BA[1:0], sdr_A[15:0]                        bank / address
//   sdr_D[DATA_W-1:0], sdr_DQM                      write data / beat mask
//   sdr_Q[DATA_W-1:0], sdr_Q_vld                    read data / valid
//   dev_rdy, proto_err[3:0]                         status
interface sdr_dev_resp_if #(
  parameter int DATA_W = 16
);
  logic              sdr_CKE;
  logic              sdr_CSn;
  logic              sdr_RASn;
  logic              sdr_CASn;
  logic              sdr_WEn;
  logic [1:0]        sdr_BA;
  logic [15:0]       sdr_A;
  logic [DATA_W-1:0] sdr_D;
  logic              sdr_DQM;
  logic [DATA_W-1:0] sdr_Q;
  logic              sdr_Q_vld;
  logic              dev_rdy;
  logic [3:0]        proto_err;

  modport master (
    output sdr_CKE, sdr_CSn, sdr_RASn, sdr_CASn, sdr_WEn, sdr_BA, sdr_A, sdr_D, sdr_DQM,
    input  sdr_Q, sdr_Q_vld, dev_rdy, proto_err
  );

  modport slave (
    input  sdr_CKE, sdr_CSn, sdr_RASn, sdr_CASn, sdr_WEn, sdr_BA, sdr_A, sdr_D, sdr_DQM,
    output sdr_Q, sdr_Q_vld, dev_rdy, proto_err
  );
endinterface

// File: rtl/sdr_dev_resp.sv
// sdr_dev_resp: SDRAM device responder, the memory end of the SDR command bus.
// Decodes commands, tracks the init sequence, per-bank open rows, the mode
// register (CL/BL) and bursts, stores data in an on-chip array and returns
// read data CL cycles after each read beat is issued. Protocol violations are
// collected in sticky proto_err bits.
// Ports:
//   pclk    clock
//   preset  synchronous reset, active-high
//   sdr     sdr_dev_resp_if.slave (command inputs, read data, dev_rdy, proto_err)
// Build option: define SDR_RESP_TCHK_EN to add per-bank tRCD/tRP checking
//   (violations set proto_err[3]; the command still executes).
//
// Init FSM
//   state     | meaning
//   WAIT_PRE  | after reset, waiting for PRECHARGE with A10=1
//   REF1      | waiting for first AUTO REFRESH
//   REF2      | waiting for second AUTO REFRESH
//   WAIT_MRS  | waiting for MODE REGISTER SET
//   READY     | init done, all commands decoded
module sdr_dev_resp #(
  parameter int DATA_W = 16,
  parameter int ROW_W  = 4,
  parameter int COL_W  = 4,
  parameter int T_RCD  = 2,
  parameter int T_RP   = 2
) (
  input logic           pclk,
  input logic           preset,
  sdr_dev_resp_if.slave sdr
);
  localparam int AW    = 2 + ROW_W + COL_W;
  localparam int DEPTH = 1 << AW;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_MRS = 3'b000;

  typedef enum logic [2:0] {
    S_WAIT_PRE, S_REF1, S_REF2, S_WAIT_MRS, S_READY
  } init_t;

  init_t state_q, state_d;

  // command decode
  logic       cmd_vld, cmd_nonnop;
  logic [2:0] cmd;
  logic [1:0] ba;
  logic       a10;
  logic       is_act, is_rd, is_wr, is_pre, is_ref, is_mrs;
  logic       unused_a;

  assign cmd_vld    = sdr.sdr_CKE & ~sdr.sdr_CSn;
  assign cmd        = {sdr.sdr_RASn, sdr.sdr_CASn, sdr.sdr_WEn};
  assign cmd_nonnop = cmd_vld && (cmd != C_NOP);
  assign ba         = sdr.sdr_BA;
  assign a10        = sdr.sdr_A[10];
  assign is_act     = cmd_vld && (cmd == C_ACT);
  assign is_rd      = cmd_vld && (cmd == C_RD);
  assign is_wr      = cmd_vld && (cmd == C_WR);
  assign is_pre     = cmd_vld && (cmd == C_PRE);
  assign is_ref     = cmd_vld && (cmd == C_REF);
  assign is_mrs     = cmd_vld && (cmd == C_MRS);
  assign unused_a   = ^sdr.sdr_A;

  // init FSM: state register
  always_ff @(posedge pclk) begin
    if (preset) state_q <= S_WAIT_PRE;
    else        state_q <= state_d;
  end

  // init FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_PRE: if (is_pre && a10) state_d = S_REF1;
      S_REF1:     if (is_ref)        state_d = S_REF2;
      S_REF2:     if (is_ref)        state_d = S_WAIT_MRS;
      S_WAIT_MRS: if (is_mrs)        state_d = S_READY;
      S_READY:                       state_d = S_READY;
      default:                       state_d = S_WAIT_PRE;
    endcase
  end

  // init FSM: outputs. accept marks a command this state acts on; any other
  // non-NOP command before READY is dropped and flagged.
  logic accept, init_err, dev_rdy_c;
  always_comb begin
    accept    = 1'b0;
    init_err  = 1'b0;
    dev_rdy_c = 1'b0;
    case (state_q)
      S_WAIT_PRE: accept = is_pre && a10;
      S_REF1,
      S_REF2:     accept = is_ref;
      S_WAIT_MRS: accept = is_mrs;
      S_READY: begin
        accept    = cmd_nonnop;
        dev_rdy_c = 1'b1;
      end
      default:    accept = 1'b0;
    endcase
    if (state_q != S_READY) init_err = cmd_nonnop && !accept;
  end

  logic act_ok, pre_ok, mrs_ok, rdwr_ok;
  assign act_ok  = accept && is_act;
  assign pre_ok  = accept && is_pre;
  assign mrs_ok  = accept && is_mrs;
  assign rdwr_ok = accept && (is_rd || is_wr);

  // mode register
  logic       cl3_q;
  logic [3:0] bl_q;
  logic [3:0] mrs_bl;
  logic       mrs_cl_ok;

  assign mrs_cl_ok = (sdr.sdr_A[6:4] == 3'd2) || (sdr.sdr_A[6:4] == 3'd3);

  always_comb begin
    case (sdr.sdr_A[2:0])
      3'd0:    mrs_bl = 4'd1;
      3'd1:    mrs_bl = 4'd2;
      3'd2:    mrs_bl = 4'd4;
      3'd3:    mrs_bl = 4'd8;
      default: mrs_bl = 4'd1;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      cl3_q <= 1'b0;
      bl_q  <= 4'd1;
    end else if (mrs_ok) begin
      if (mrs_cl_ok) cl3_q <= (sdr.sdr_A[6:4] == 3'd3);
      bl_q <= mrs_bl;
    end
  end

  // bank state
  logic [3:0]       bank_open_q;
  logic [ROW_W-1:0] bank_row_q [4];

  always_ff @(posedge pclk) begin
    if (preset) begin
      bank_open_q <= '0;
      for (int b = 0; b < 4; b++) bank_row_q[b] <= '0;
    end else if (act_ok && !bank_open_q[ba]) begin
      bank_open_q[ba] <= 1'b1;
      bank_row_q[ba]  <= sdr.sdr_A[ROW_W-1:0];
    end else if (pre_ok) begin
      if (a10) bank_open_q     <= '0;
      else     bank_open_q[ba] <= 1'b0;
    end
  end

  // burst engine: beat 0 runs in the command cycle straight from the inputs,
  // later beats from the captured burst registers.
  logic             bst_act_q, bst_rd_q;
  logic [1:0]       bst_ba_q;
  logic [ROW_W-1:0] bst_row_q;
  logic [COL_W-1:0] bst_col_q;
  logic [3:0]       bst_idx_q, bst_len_q;

  logic             beat_en, beat_rd;
  logic [1:0]       beat_ba;
  logic [ROW_W-1:0] beat_row;
  logic [COL_W-1:0] beat_col;
  logic [3:0]       beat_idx, beat_len;

  always_comb begin
    beat_en  = 1'b0;
    beat_rd  = bst_rd_q;
    beat_ba  = bst_ba_q;
    beat_row = bst_row_q;
    beat_col = bst_col_q;
    beat_idx = bst_idx_q;
    beat_len = bst_len_q;
    if (rdwr_ok) begin
      beat_en  = bank_open_q[ba];
      beat_rd  = is_rd;
      beat_ba  = ba;
      beat_row = bank_row_q[ba];
      beat_col = sdr.sdr_A[COL_W-1:0];
      beat_idx = 4'd0;
      beat_len = bl_q;
    end else if (bst_act_q && sdr.sdr_CKE) begin
      beat_en = 1'b1;
    end
  end

  // sequential order wrapping inside the BL-aligned column block
  logic [COL_W-1:0] bl_mask, col_sum, beat_col_k;
  logic [AW-1:0]    mem_addr;
  logic             wr_en, rd_issue;

  assign bl_mask    = COL_W'(beat_len - 4'd1);
  assign col_sum    = beat_col + COL_W'(beat_idx);
  assign beat_col_k = (beat_col & ~bl_mask) | (col_sum & bl_mask);
  assign mem_addr   = {beat_ba, beat_row, beat_col_k};
  assign wr_en      = beat_en && !beat_rd && !sdr.sdr_DQM && !preset;
  assign rd_issue   = beat_en && beat_rd && !sdr.sdr_DQM;

  always_ff @(posedge pclk) begin
    if (preset) begin
      bst_act_q <= 1'b0;
      bst_rd_q  <= 1'b0;
      bst_ba_q  <= '0;
      bst_row_q <= '0;
      bst_col_q <= '0;
      bst_idx_q <= '0;
      bst_len_q <= 4'd1;
    end else if (sdr.sdr_CKE) begin
      if (rdwr_ok) begin
        // a new READ/WRITE always ends the running burst, even to a closed bank
        bst_act_q <= bank_open_q[ba] && (bl_q != 4'd1);
        bst_rd_q  <= is_rd;
        bst_ba_q  <= ba;
        bst_row_q <= bank_row_q[ba];
        bst_col_q <= sdr.sdr_A[COL_W-1:0];
        bst_idx_q <= 4'd1;
        bst_len_q <= bl_q;
      end else if (bst_act_q) begin
        bst_idx_q <= bst_idx_q + 4'd1;
        // PRE of the burst bank lets this cycle's beat complete, then stops
        if ((bst_idx_q == bst_len_q - 4'd1) || (pre_ok && (a10 || (ba == bst_ba_q))))
          bst_act_q <= 1'b0;
      end
    end
  end

  // storage (not cleared by reset)
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge pclk) begin
    if (wr_en) mem[mem_addr] <= sdr.sdr_D;
  end

  // read pipeline: issue -> p0 -> p1; output taps p0 for CL=2, p1 for CL=3
  logic              p0_vld_q, p1_vld_q, q_vld_q;
  logic [DATA_W-1:0] p0_dat_q, p1_dat_q, q_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      p0_vld_q <= 1'b0;
      p1_vld_q <= 1'b0;
      p0_dat_q <= '0;
      p1_dat_q <= '0;
      q_vld_q  <= 1'b0;
      q_q      <= '0;
    end else if (sdr.sdr_CKE) begin
      p0_vld_q <= rd_issue;
      p0_dat_q <= mem[mem_addr];
      p1_vld_q <= p0_vld_q;
      p1_dat_q <= p0_dat_q;
      if (cl3_q) begin
        q_vld_q <= p1_vld_q;
        if (p1_vld_q) q_q <= p1_dat_q;
      end else begin
        q_vld_q <= p0_vld_q;
        if (p0_vld_q) q_q <= p0_dat_q;
      end
    end
  end

  // timing checks
  logic tchk_err;
`ifdef SDR_RESP_TCHK_EN
  logic [3:0] rcd_cnt_q [4];
  logic [3:0] rp_cnt_q  [4];

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int b = 0; b < 4; b++) begin
        rcd_cnt_q[b] <= '0;
        rp_cnt_q[b]  <= '0;
      end
    end else if (sdr.sdr_CKE) begin
      for (int b = 0; b < 4; b++) begin
        if (act_ok && (ba == 2'(b)))              rcd_cnt_q[b] <= 4'(T_RCD - 1);
        else if (rcd_cnt_q[b] != 4'd0)            rcd_cnt_q[b] <= rcd_cnt_q[b] - 4'd1;
        if (pre_ok && (a10 || (ba == 2'(b))))     rp_cnt_q[b]  <= 4'(T_RP - 1);
        else if (rp_cnt_q[b] != 4'd0)             rp_cnt_q[b]  <= rp_cnt_q[b] - 4'd1;
      end
    end
  end

  assign tchk_err = (rdwr_ok && (rcd_cnt_q[ba] != 4'd0)) || (act_ok && (rp_cnt_q[ba] != 4'd0));
`else
  assign tchk_err = 1'b0;
`endif

  // sticky error flags
  logic [3:0] err_q, err_set;

  assign err_set[0] = init_err;
  assign err_set[1] = rdwr_ok && !bank_open_q[ba];
  assign err_set[2] = act_ok && bank_open_q[ba];
  assign err_set[3] = (mrs_ok && !mrs_cl_ok) || tchk_err;

  always_ff @(posedge pclk) begin
    if (preset) err_q <= '0;
    else        err_q <= err_q | err_set;
  end

  assign sdr.sdr_Q     = q_q;
  assign sdr.sdr_Q_vld = q_vld_q;
  assign sdr.dev_rdy   = dev_rdy_c;
  assign sdr.proto_err = err_q;

endmodule

// File: tb/tb_sdr_dev_resp.sv
// tb_sdr_dev_resp: directed and randomized bench for sdr_dev_resp.
// The reference model schedules burst beats as (logical cycle, bank, address)
// events; logical time advances only on CKE=1 cycles. Expected read data is
// booked CL logical cycles after each read beat.
module tb_sdr_dev_resp;
  localparam int DATA_W = 16;
  localparam int T_RCD  = 2;
  localparam int T_RP   = 2;

  localparam logic [2:0] NOP = 3'b111;
  localparam logic [2:0] ACT = 3'b011;
  localparam logic [2:0] RD  = 3'b101;
  localparam logic [2:0] WR  = 3'b100;
  localparam logic [2:0] PRE = 3'b010;
  localparam logic [2:0] REF = 3'b001;
  localparam logic [2:0] MRS = 3'b000;

  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  sdr_dev_resp_if #(.DATA_W(DATA_W)) bus ();

  sdr_dev_resp #(
    .DATA_W(DATA_W), .ROW_W(4), .COL_W(4), .T_RCD(T_RCD), .T_RP(T_RP)
  ) dut (
    .pclk(pclk),
    .preset(preset),
    .sdr(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  typedef struct {
    int cyc;
    bit rd;
    int ba;
    int addr;
  } beat_t;

  int          L = 0;
  int          m_stage;
  bit          m_open [4];
  int          m_row  [4];
  int          m_cl, m_bl;
  logic [3:0]  m_err;
  int          last_act [4];
  int          last_pre [4];
  logic [15:0] m_mem [int];
  beat_t       pend [$];
  bit          exp_vld [int];
  logic [15:0] exp_q [int];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_stage = 0;
    m_cl    = 2;
    m_bl    = 1;
    m_err   = 4'b0;
    for (int b = 0; b < 4; b++) begin
      m_open[b]   = 1'b0;
      m_row[b]    = 0;
      last_act[b] = -1000;
      last_pre[b] = -1000;
    end
    pend.delete();
    exp_vld.delete();
    exp_q.delete();
  endtask

  task automatic model_cycle(bit cke, bit csn, logic [2:0] cmd, int ba, logic [15:0] a,
                             logic [15:0] d, bit dqm);
    bit    nonnop, accept;
    beat_t keep [$];
    beat_t bt;
    if (!cke) return;
    nonnop = !csn && (cmd != NOP);
    case (m_stage)
      0:       accept = nonnop && (cmd == PRE) && a[10];
      1, 2:    accept = nonnop && (cmd == REF);
      3:       accept = nonnop && (cmd == MRS);
      default: accept = nonnop;
    endcase
    if (nonnop && !accept) m_err[0] = 1'b1;
    if (accept) begin
      if (m_stage < 4) m_stage++;
      case (cmd)
        ACT: begin
`ifdef SDR_RESP_TCHK_EN
          if (L - last_pre[ba] < T_RP) m_err[3] = 1'b1;
`endif
          last_act[ba] = L;
          if (m_open[ba]) m_err[2] = 1'b1;
          else begin
            m_open[ba] = 1'b1;
            m_row[ba]  = int'(a[3:0]);
          end
        end
        RD, WR: begin
`ifdef SDR_RESP_TCHK_EN
          if (L - last_act[ba] < T_RCD) m_err[3] = 1'b1;
`endif
          keep = {};
          foreach (pend[i]) if (pend[i].cyc < L) keep.push_back(pend[i]);
          pend = keep;
          if (!m_open[ba]) m_err[1] = 1'b1;
          else begin
            for (int k = 0; k < m_bl; k++) begin
              int col, colk, mask;
              col  = int'(a[3:0]);
              mask = m_bl - 1;
              colk = (col & (15 & ~mask)) | ((col + k) & mask);
              bt.cyc  = L + k;
              bt.rd   = (cmd == RD);
              bt.ba   = ba;
              bt.addr = ba * 256 + m_row[ba] * 16 + colk;
              pend.push_back(bt);
            end
          end
        end
        PRE: begin
          keep = {};
          foreach (pend[i])
            if (!(pend[i].cyc > L && (a[10] || pend[i].ba == ba))) keep.push_back(pend[i]);
          pend = keep;
          for (int b = 0; b < 4; b++)
            if (a[10] || b == ba) begin
              m_open[b]   = 1'b0;
              last_pre[b] = L;
            end
        end
        MRS: begin
          if (a[6:4] == 3'd2 || a[6:4] == 3'd3) m_cl = int'(a[6:4]);
          else m_err[3] = 1'b1;
          m_bl = (a[2:0] < 3'd4) ? (1 << a[2:0]) : 1;
        end
        default: ;
      endcase
    end
    keep = {};
    foreach (pend[i]) begin
      if (pend[i].cyc == L) begin
        if (!dqm) begin
          if (pend[i].rd) begin
            exp_vld[L + m_cl] = 1'b1;
            if (m_mem.exists(pend[i].addr)) exp_q[L + m_cl] = m_mem[pend[i].addr];
          end else begin
            m_mem[pend[i].addr] = d;
          end
        end
      end else keep.push_back(pend[i]);
    end
    pend = keep;
    L++;
  endtask

  task automatic chk_outputs();
    chk("dev_rdy", bus.dev_rdy, (m_stage == 4));
    chk("proto_err", bus.proto_err, m_err);
    chk("q_vld", bus.sdr_Q_vld, exp_vld.exists(L));
    if (exp_vld.exists(L) && exp_q.exists(L)) chk("q_data", bus.sdr_Q, exp_q[L]);
  endtask

  task automatic cyc(bit cke, bit csn, logic [2:0] cmd, logic [1:0] ba, logic [15:0] a,
                     logic [15:0] d, bit dqm);
    @(negedge pclk);
    preset       = 1'b0;
    bus.sdr_CKE  = cke;
    bus.sdr_CSn  = csn;
    {bus.sdr_RASn, bus.sdr_CASn, bus.sdr_WEn} = cmd;
    bus.sdr_BA   = ba;
    bus.sdr_A    = a;
    bus.sdr_D    = d;
    bus.sdr_DQM  = dqm;
    model_cycle(cke, csn, cmd, int'(ba), a, d, dqm);
    @(posedge pclk);
    #1;
    chk_outputs();
  endtask

  task automatic nop(int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, NOP, 2'd0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    preset       = 1'b1;
    bus.sdr_CKE  = 1'b1;
    bus.sdr_CSn  = 1'b1;
    {bus.sdr_RASn, bus.sdr_CASn, bus.sdr_WEn} = NOP;
    bus.sdr_DQM  = 1'b0;
    @(posedge pclk);
    #1;
    model_reset();
    chk("rst_q", bus.sdr_Q, 16'h0);
    chk("rst_q_vld", bus.sdr_Q_vld, 1'b0);
    chk("rst_dev_rdy", bus.dev_rdy, 1'b0);
    chk("rst_proto_err", bus.proto_err, 4'b0);
  endtask

  task automatic do_init(logic [15:0] mode);
    cyc(1'b1, 1'b0, PRE, 2'd0, 16'h0400, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, REF, 2'd0, 16'h0, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, REF, 2'd0, 16'h0, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, MRS, 2'd0, mode, 16'h0, 1'b0);
  endtask

  initial begin
    logic [15:0] rd_exp [4];
    logic [15:0] a;
    logic [2:0]  c;
    int          r;
    rd_exp[0] = 16'hA002; rd_exp[1] = 16'hA003; rd_exp[2] = 16'hA000; rd_exp[3] = 16'hA001;

    preset      = 1'b1;
    bus.sdr_CKE = 1'b1;
    bus.sdr_CSn = 1'b1;
    {bus.sdr_RASn, bus.sdr_CASn, bus.sdr_WEn} = NOP;
    bus.sdr_BA  = 2'd0;
    bus.sdr_A   = 16'h0;
    bus.sdr_D   = 16'h0;
    bus.sdr_DQM = 1'b0;
    model_reset();

    // reset values, then ACT before init
    do_reset();
    cyc(1'b1, 1'b0, ACT, 2'd0, 16'h0001, 16'h0, 1'b0);
    chk("pre_init_err", bus.proto_err, 4'b0001);
    chk("pre_init_rdy", bus.dev_rdy, 1'b0);
    nop(2);

    // init with CL=2 BL=4
    do_reset();
    do_init(16'h0022);
    chk("init_rdy", bus.dev_rdy, 1'b1);
    chk("init_err", bus.proto_err, 4'b0);

    // wrapped write burst then read from col 12
    cyc(1'b1, 1'b0, ACT, 2'd1, 16'h0003, 16'h0, 1'b0);
    nop(2);
    cyc(1'b1, 1'b0, WR,  2'd1, 16'h000E, 16'hA000, 1'b0);
    cyc(1'b1, 1'b0, NOP, 2'd0, 16'h0,    16'hA001, 1'b0);
    cyc(1'b1, 1'b0, NOP, 2'd0, 16'h0,    16'hA002, 1'b0);
    cyc(1'b1, 1'b0, NOP, 2'd0, 16'h0,    16'hA003, 1'b0);
    nop(1);
    cyc(1'b1, 1'b0, RD, 2'd1, 16'h000C, 16'h0, 1'b0);
    chk("rd_lat_cmd1", bus.sdr_Q_vld, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nop(1);
      chk("rd_burst_vld", bus.sdr_Q_vld, 1'b1);
      chk("rd_burst_data", bus.sdr_Q, rd_exp[i]);
    end
    nop(1);
    chk("rd_burst_end", bus.sdr_Q_vld, 1'b0);

    // closed-bank read, ACT to open bank
    cyc(1'b1, 1'b0, RD, 2'd2, 16'h0000, 16'h0, 1'b0);
    nop(3);
    cyc(1'b1, 1'b0, ACT, 2'd1, 16'h0005, 16'h0, 1'b0);
    chk("err_closed_open", bus.proto_err, 4'b0110);
    nop(2);

    // CKE freeze in the middle of a read burst
    cyc(1'b1, 1'b0, RD, 2'd1, 16'h000D, 16'h0, 1'b0);
    nop(2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, RD, 2'd3, 16'h0, 16'h0, 1'b0);
    nop(6);

    // PRE of the burst bank cuts the burst short
    cyc(1'b1, 1'b0, RD, 2'd1, 16'h000C, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, PRE, 2'd1, 16'h0000, 16'h0, 1'b0);
    nop(5);

`ifdef SDR_RESP_TCHK_EN
    cyc(1'b1, 1'b0, ACT, 2'd0, 16'h0000, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, RD,  2'd0, 16'h0000, 16'h0, 1'b0);
    chk("tchk_rcd", bus.proto_err[3], 1'b1);
    nop(6);
`endif

    // reset mid-burst: data array survives, outputs clear at once
    cyc(1'b1, 1'b0, ACT, 2'd1, 16'h0003, 16'h0, 1'b0);
    nop(2);
    cyc(1'b1, 1'b0, RD, 2'd1, 16'h000C, 16'h0, 1'b0);
    nop(1);
    do_reset();
    nop(3);

    // randomized phases, fresh init with random mode each time
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      a = 16'h0;
      a[6:4] = 3'($urandom_range(1, 3));
      a[2:0] = 3'($urandom_range(0, 7));
      do_init(a);
      for (int i = 0; i < 250; i++) begin
        r = $urandom_range(0, 99);
        if      (r < 40) c = NOP;
        else if (r < 55) c = ACT;
        else if (r < 70) c = RD;
        else if (r < 85) c = WR;
        else if (r < 95) c = PRE;
        else             c = REF;
        a = 16'($urandom);
        if (c == ACT) a[3:0] = 4'($urandom_range(0, 1));
        cyc(($urandom_range(0, 15) != 0), ($urandom_range(0, 15) == 0), c,
            2'($urandom_range(0, 3)), a, 16'($urandom), ($urandom_range(0, 7) == 0));
      end
      nop(12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
